// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// next-PC select codes, the NOP word and the opcode constants the decoder
// understands (R, I, I-load, S, B).
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_FLUSH = 2'd3
  } ifu_state_e;

  typedef enum logic [1:0] {
    PC_KEEP   = 2'd0,
    PC_INC    = 2'd1,
    PC_TARGET = 2'd2,
    PC_PEND   = 2'd3
  } pc_sel_e;

  localparam logic [31:0] IFU_NOP  = 32'h0000_0013;

  localparam logic [6:0]  OPC_R    = 7'b0110011;
  localparam logic [6:0]  OPC_I    = 7'b0010011;
  localparam logic [6:0]  OPC_LOAD = 7'b0000011;
  localparam logic [6:0]  OPC_S    = 7'b0100011;
  localparam logic [6:0]  OPC_B    = 7'b1100011;

  function automatic logic opcode_is_legal(input logic [6:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      OPC_R, OPC_I, OPC_LOAD, OPC_S, OPC_B: legal = 1'b1;
      default:                              legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_gen.sv
// Program counter generator: holds the PC and the pending redirect target,
// forces targets to word alignment and picks the next PC from the FSM's
// select code (keep / +4 / redirect target / pending target).
module ifu_pc_gen
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_PcSel,
  input  logic        i_PendWr,
  input  logic [31:0] i_Target,
  output logic [31:0] o_PC
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] target_aligned;
  logic [31:0] reset_pc_aligned;

  assign target_aligned   = {i_Target[31:2], 2'b00};
  assign reset_pc_aligned = {RESET_PC[31:2], 2'b00};

  // Next-PC mux; the +4 wraps naturally modulo 2^32.
  always_comb begin
    pc_d = pc_q;
    case (pc_sel_e'(i_PcSel))
      PC_KEEP:   pc_d = pc_q;
      PC_INC:    pc_d = pc_q + 32'd4;
      PC_TARGET: pc_d = target_aligned;
      PC_PEND:   pc_d = pend_q;
      default:   pc_d = pc_q;
    endcase
    pend_d = i_PendWr ? target_aligned : pend_q;
  end

  // PC and pending-target registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q   <= reset_pc_aligned;
      pend_q <= reset_pc_aligned;
    end else begin
      pc_q   <= pc_d;
      pend_q <= pend_d;
    end
  end

  assign o_PC = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: single-outstanding word fetch, holds the fetched
// instruction until the core accepts it, handles execute-stage redirects
// (including discarding a response that is already in flight).
// Optional feature: define IFU_OPCODE_CHECK_EN to add o_IllegalOp.
//
// Handshakes: memory side keeps o_IMemReq high with o_IMemAddr stable until
// the edge where i_IMemAck=1 (data valid that same cycle); ack is ignored
// while no request is up. Core side transfers on an edge where
// o_InstValid=1 and i_InstReady=1.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = IFU_NOP
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_IMemReq,
  output logic [31:0] o_IMemAddr,
  input  logic        i_IMemAck,
  input  logic [31:0] i_IMemData,
  output logic        o_InstValid,
  input  logic        i_InstReady,
  output logic [31:0] o_Inst,
  output logic [6:0]  o_OPCode,
  output logic [31:0] o_PC,
  input  logic        i_Redirect,
  input  logic [31:0] i_RedirectPC,
  output logic [1:0]  o_DbgState
`ifdef IFU_OPCODE_CHECK_EN
  ,
  output logic        o_IllegalOp
`endif
);

  ifu_state_e  state_q;
  logic        req_q;
  logic        valid_q;
  logic [31:0] inst_q;
  logic [31:0] pc;
  pc_sel_e     pc_sel;
  logic        pend_wr;
  logic        inst_latch;
  logic        inst_release;

  // Next-PC control and latch/release strobes from the current state.
  always_comb begin
    pc_sel       = PC_KEEP;
    pend_wr      = 1'b0;
    inst_latch   = 1'b0;
    inst_release = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_Redirect) pc_sel = PC_TARGET;
      end
      S_FETCH: begin
        if (i_IMemAck) begin
          if (i_Redirect) pc_sel = PC_TARGET;
          else            inst_latch = 1'b1;
        end else if (i_Redirect) begin
          pend_wr = 1'b1;
        end
      end
      S_HOLD: begin
        if (i_Redirect) begin
          pc_sel       = PC_TARGET;
          inst_release = 1'b1;
        end else if (i_InstReady) begin
          pc_sel       = PC_INC;
          inst_release = 1'b1;
        end
      end
      S_FLUSH: begin
        // A redirect here replaces the pending target; if the stale ack
        // lands in the same cycle the newest target is used directly.
        if (i_Redirect) pend_wr = 1'b1;
        if (i_IMemAck)  pc_sel  = i_Redirect ? PC_TARGET : PC_PEND;
      end
      default: ;
    endcase
  end

  ifu_pc_gen #(
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_PcSel  (pc_sel),
    .i_PendWr (pend_wr),
    .i_Target (i_RedirectPC),
    .o_PC     (pc)
  );

  // Fetch FSM with registered request / valid / instruction outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      inst_q  <= NOP_INST;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_FETCH;
          req_q   <= 1'b1;
        end
        S_FETCH: begin
          if (inst_latch) begin
            state_q <= S_HOLD;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            inst_q  <= i_IMemData;
          end else if (!i_IMemAck && i_Redirect) begin
            state_q <= S_FLUSH;
          end
        end
        S_HOLD: begin
          if (inst_release) begin
            state_q <= S_FETCH;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
            inst_q  <= NOP_INST;
          end
        end
        S_FLUSH: begin
          if (i_IMemAck) state_q <= S_FETCH;
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
          inst_q  <= NOP_INST;
        end
      endcase
    end
  end

`ifdef IFU_OPCODE_CHECK_EN
  logic ill_q;

  // Illegal-opcode flag, captured alongside the instruction and cleared when
  // the instruction is released.
  always_ff @(posedge i_clk) begin
    if (i_rst || inst_release) ill_q <= 1'b0;
    else if (inst_latch)       ill_q <= !opcode_is_legal(i_IMemData[6:0]);
  end

  assign o_IllegalOp = ill_q;
`endif

  assign o_IMemReq   = req_q;
  assign o_IMemAddr  = pc;
  assign o_PC        = pc;
  assign o_InstValid = valid_q;
  assign o_Inst      = inst_q;
  assign o_OPCode    = inst_q[6:0];
  assign o_DbgState  = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios with literal expectations,
// then randomized memory latency / ready / redirect / reset traffic, all
// checked every cycle against a transaction-level model.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ack;
  logic [31:0] data;
  logic        ready;
  logic        redir;
  logic [31:0] rpc;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        inst_valid;
  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [31:0] pc_out;
  logic [1:0]  dbg_state;
`ifdef IFU_OPCODE_CHECK_EN
  logic        illegal_op;
`endif

  instr_fetch_unit dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .o_IMemReq    (imem_req),
    .o_IMemAddr   (imem_addr),
    .i_IMemAck    (ack),
    .i_IMemData   (data),
    .o_InstValid  (inst_valid),
    .i_InstReady  (ready),
    .o_Inst       (inst),
    .o_OPCode     (opcode),
    .o_PC         (pc_out),
    .i_Redirect   (redir),
    .i_RedirectPC (rpc),
    .o_DbgState   (dbg_state)
`ifdef IFU_OPCODE_CHECK_EN
    ,
    .o_IllegalOp  (illegal_op)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks: has the unit started, is a fetch outstanding, is that fetch
  // stale, is an instruction held, plus PC / pending target / held word.
  bit          m_known = 1'b0;
  bit          m_started, m_req, m_stale, m_held;
  logic [31:0] m_pc, m_pend, m_inst;

  function automatic logic [31:0] align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  function automatic logic m_illegal(input logic [6:0] op);
    case (op)
      7'h33, 7'h13, 7'h03, 7'h23, 7'h63: return 1'b0;
      default:                           return 1'b1;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst === 1'b1) begin
      m_known   <= 1'b1;
      m_started <= 1'b0;
      m_req     <= 1'b0;
      m_stale   <= 1'b0;
      m_held    <= 1'b0;
      m_pc      <= 32'h0;
      m_pend    <= 32'h0;
      m_inst    <= NOP;
    end else if (m_known) begin
      if (!m_started) begin
        m_started <= 1'b1;
        m_req     <= 1'b1;
        if (redir) m_pc <= align(rpc);
      end else if (m_held) begin
        if (redir) begin
          m_held <= 1'b0; m_req <= 1'b1; m_pc <= align(rpc);
        end else if (ready) begin
          m_held <= 1'b0; m_req <= 1'b1; m_pc <= m_pc + 32'd4;
        end
      end else if (m_req && !m_stale) begin
        if (ack) begin
          if (redir) m_pc <= align(rpc);
          else begin
            m_held <= 1'b1; m_inst <= data; m_req <= 1'b0;
          end
        end else if (redir) begin
          m_stale <= 1'b1; m_pend <= align(rpc);
        end
      end else if (m_req && m_stale) begin
        if (redir) m_pend <= align(rpc);
        if (ack) begin
          m_stale <= 1'b0;
          m_pc    <= redir ? align(rpc) : m_pend;
        end
      end
    end
  end

  // ---------------- scoreboard: compare every cycle ----------------
  always @(negedge clk) begin
    if (m_known) begin
      chk("req",   {31'b0, imem_req},   {31'b0, m_req});
      chk("addr",  imem_addr,           m_pc);
      chk("pc",    pc_out,              m_pc);
      chk("valid", {31'b0, inst_valid}, {31'b0, m_held});
      chk("inst",  inst,                m_held ? m_inst : NOP);
      chk("opc",   {25'b0, opcode},     {25'b0, (m_held ? m_inst[6:0] : NOP[6:0])});
`ifdef IFU_OPCODE_CHECK_EN
      chk("illegal", {31'b0, illegal_op}, {31'b0, (m_held && m_illegal(m_inst[6:0]))});
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic r, input logic a, input logic [31:0] d,
                     input logic rd, input logic rdy, input logic [31:0] t);
    rst = r; ack = a; data = d; redir = rd; ready = rdy; rpc = t;
    @(posedge clk);
    #1;
  endtask

  int          mw;
  bit          req_was;
  logic [31:0] legal_ops [5];

  initial begin
    legal_ops[0] = 32'h33; legal_ops[1] = 32'h13; legal_ops[2] = 32'h03;
    legal_ops[3] = 32'h23; legal_ops[4] = 32'h63;

    // Reset state
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("rst_req",   {31'b0, imem_req},   32'd0);
    chk("rst_addr",  imem_addr,           32'h0);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst",  inst,                32'h0000_0013);
    chk("rst_opc",   {25'b0, opcode},     32'h13);

    // Release: request at 0 one cycle later, zero-wait ack
    cyc(0, 0, 0, 0, 0, 0);
    chk("boot_req",  {31'b0, imem_req}, 32'd1);
    chk("boot_addr", imem_addr,         32'h0);
    cyc(0, 1, 32'h00A0_0093, 0, 0, 0);
    chk("ack_valid", {31'b0, inst_valid}, 32'd1);
    chk("ack_opc",   {25'b0, opcode},     32'h13);
    chk("ack_req",   {31'b0, imem_req},   32'd0);

    // Redirect to 0x103 in HOLD with ready: redirect wins
    cyc(0, 0, 0, 1, 1, 32'h0000_0103);
    chk("redir_addr",  imem_addr,           32'h0000_0100);
    chk("redir_valid", {31'b0, inst_valid}, 32'd0);
    chk("redir_pc",    pc_out,              32'h0000_0100);

    // Three wait cycles with ready held: address stable
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 1, 0);
      chk("wait_addr", imem_addr,         32'h0000_0100);
      chk("wait_req",  {31'b0, imem_req}, 32'd1);
    end
    cyc(0, 1, 32'h0000_0033, 0, 1, 0);
    chk("w_valid", {31'b0, inst_valid}, 32'd1);
    chk("w_noreq", {31'b0, imem_req},   32'd0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("acc_addr", imem_addr,           32'h0000_0104);
    chk("acc_req",  {31'b0, imem_req},   32'd1);

    // Redirect to 0x40 during fetch at 0x104, then redirects during fetch at 0x40
    cyc(0, 0, 0, 1, 0, 32'h0000_0040);
    chk("fl_addr", imem_addr, 32'h0000_0104);
    cyc(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
    chk("fl_drop", {31'b0, inst_valid}, 32'd0);
    chk("fl_next", imem_addr,           32'h0000_0040);
    cyc(0, 0, 0, 1, 0, 32'h0000_0080);
    chk("fl2_addr", imem_addr, 32'h0000_0040);
    cyc(0, 0, 0, 1, 0, 32'h0000_0200);
    chk("fl3_addr", imem_addr,         32'h0000_0040);
    chk("fl3_req",  {31'b0, imem_req}, 32'd1);
    cyc(0, 1, 32'h1234_5677, 0, 0, 0);
    chk("fl_valid", {31'b0, inst_valid}, 32'd0);
    chk("fl_tgt",   imem_addr,           32'h0000_0200);

    // Ack plus redirect in FETCH: data discarded, misaligned target forced
    cyc(0, 1, 32'h0000_0013, 1, 0, 32'hFFFF_FFFE);
    chk("ar_valid", {31'b0, inst_valid}, 32'd0);
    chk("ar_addr",  imem_addr,           32'hFFFF_FFFC);
    cyc(0, 1, 32'h0000_007F, 0, 0, 0);
    chk("top_pc",  pc_out,          32'hFFFF_FFFC);
    chk("top_opc", {25'b0, opcode}, 32'h7F);
`ifdef IFU_OPCODE_CHECK_EN
    chk("ill_7f", {31'b0, illegal_op}, 32'd1);
`endif
    cyc(0, 0, 0, 0, 1, 0);
    chk("wrap_addr", imem_addr,         32'h0);
    chk("wrap_req",  {31'b0, imem_req}, 32'd1);
    cyc(0, 1, 32'h0000_0033, 0, 0, 0);
    chk("r_opc", {25'b0, opcode}, 32'h33);
`ifdef IFU_OPCODE_CHECK_EN
    chk("ill_33", {31'b0, illegal_op}, 32'd0);
`endif

    // Reset mid-request
    cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("mid_rst_req",  {31'b0, imem_req}, 32'd0);
    chk("mid_rst_addr", imem_addr,         32'h0);

    // Randomized traffic
    mw = -1;
    req_was = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      logic        r, a, rd, rdy;
      logic [31:0] d, t;
      r = ($urandom_range(0, 199) == 0);
      if (rst || (ack && req_was)) mw = -1;
      req_was = imem_req;
      if (!imem_req) begin
        mw = -1;
        a  = ($urandom_range(0, 3) == 0);
      end else begin
        if (mw < 0) mw = $urandom_range(0, 3);
        if (mw == 0) a = 1'b1;
        else begin
          a = 1'b0;
          mw--;
        end
      end
      d = $urandom;
      if ($urandom_range(0, 1) == 0) d = {d[31:7], legal_ops[$urandom_range(0, 4)][6:0]};
      rdy = ($urandom_range(0, 2) != 0);
      rd  = ($urandom_range(0, 9) == 0);
      t   = $urandom;
      if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFFC;
      cyc(r, a, d, rd, rdy, t);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
